fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
Read-side consumer of the team's async FIFO, living entirely in the rd_clk domain. Drives the FIFO's rd_en/empty/rd_data interface, absorbs its 1-cycle registered read latency and presents the words as a valid/ready stream. A 2-entry output buffer gives 1 word/cycle throughput under continuous m_ready and loses no data under backpressure.

Parameters:
DATA_WIDTH, 8, word width; must equal the FIFO's DATA_WIDTH.
PKT_LEN, 4, beats per packet for m_last generation (used only with the optional feature); must be >= 1.

Ports:
rd_clk  input  1  read-domain clock, the same net as the FIFO's rd_clk.
rd_reset_n  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  read request to the FIFO.
fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accept.
m_data  output  DATA_WIDTH  output word.
m_last  output  1  last beat of a packet; tied 0 without the optional feature.
buf_count  output  2  output-buffer occupancy, 0..2.

Behaviour:
- Reset (rd_reset_n low, asynchronous): buffer occupancy 0, in-flight flag 0, both buffer entries 0, beat counter 0. Outputs: m_valid=0, m_data=0, m_last=0, buf_count=0. fifo_rd_en=0 while reset is asserted.
- Combinational signals:
  - pop = m_valid && m_ready.
  - fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2. This never over-commits the buffer.
- In-flight tracking: inflight <= fifo_rd_en, registered every cycle.
  - When inflight=1, fifo_rd_data is written into the buffer that cycle.
  - When inflight=0, fifo_rd_data is ignored. The FIFO holds stale data then.
- Buffer:
  - 2-entry in-order FIFO: head drives m_data, m_valid = (occ != 0).
  - Push (inflight) and pop in the same cycle: occ unchanged, order preserved.
  - Push into an empty buffer: the word appears at the head the next cycle.
- Handshake:
  - m_data/m_valid stay stable while m_valid && !m_ready.
  - A word transfers on every rising rd_clk edge with m_valid && m_ready.
- Latency: fifo_empty falls in cycle t -> fifo_rd_en in t -> data captured at end of t+1 -> m_valid high in t+2.
- Throughput: with m_ready held 1 and the FIFO non-empty, steady state is occ=1, inflight=1 and one word per cycle.
- Backpressure: with m_ready=0, at most 2 reads are issued beyond the last pop. fifo_rd_en drops while occ + inflight = 2.
- Boundaries:
  - fifo_empty rising with a read in flight: the in-flight word is still captured.
  - m_ready toggling every cycle: no duplicate or dropped words.
  - Reset mid-stream: buffered and in-flight words are discarded. Per-domain FIFO reset is the system's responsibility.
- buf_count = occ, registered.

Optional Feature:
Macro FIFO_RD_STREAM_LAST_EN.
- Defined:
  - A beat counter of width $clog2(PKT_LEN)+1 increments on pop and wraps to 0 after PKT_LEN-1.
  - m_last = m_valid && (beat_cnt == PKT_LEN-1).
  - PKT_LEN=1 gives m_last = m_valid.
  - Reset clears the counter.
- Undefined: no counter is built and m_last is constant 0.

Decomposition:
- Package fifo_stream_pkg holds:
  - localparam BUF_DEPTH=2 and occupancy width 2.
  - Helper function can_issue(occ, inflight, pop).
- Sub-module rd_skid_buffer: the 2-entry push/pop buffer with occ output, parameterised on DATA_WIDTH.
- The top level holds the issue logic, the in-flight flag and the optional beat counter.

Test Plan:
- Reset then idle: fifo_empty=1, m_ready=1 for 10 cycles -> fifo_rd_en=0, m_valid=0, buf_count=0 throughout.
- Streaming: FIFO model preloaded with 8'h01..8'h08, m_ready=1 -> first m_valid 2 cycles after the first fifo_rd_en, then 8 consecutive beats 01..08 with no gaps.
- Backpressure: words 8'hA0..8'hA5 with m_ready=0 for 6 cycles -> exactly 2 reads issued, buf_count=2, m_data=A0 stable. On release the outputs are A0..A5 in order.
- Alternating m_ready (1,0,1,0...) with 16 words -> all 16 delivered in order, no duplicates, buf_count never exceeds 2.
- Reset mid-stream: assert rd_reset_n=0 while buf_count=2 -> m_valid, buf_count and m_data go to 0 immediately (asynchronous), and stay 0 until new reads complete.
- FIFO_RD_STREAM_LAST_EN with PKT_LEN=4 and 12 words streamed -> m_last high on beats 4, 8 and 12 only. With m_ready stalled on beat 4, m_last stays high until that beat is accepted.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_stream_pkg: shared constants and the read-issue helper for the
// fifo_rd_stream_adapter (read side of the async FIFO, rd_clk domain).
//   BUF_DEPTH : entries in the output buffer (2)
//   OCC_W     : width of the occupancy count (0..2)
//   can_issue : 1 when one more FIFO read cannot overflow the buffer
package fifo_stream_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // Words already owned by the buffer after this cycle: stored + arriving
    // - leaving. pop implies occ >= 1, so the sum never goes negative.
    function automatic logic can_issue(input occ_t occ, input logic inflight,
                                       input logic pop);
        logic [OCC_W:0] sum;
        sum = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
        return sum < (OCC_W+1)'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// fifo_rd_stream_adapter_if: FIFO read port plus the valid/ready stream.
//   master : adapter side  (drives fifo_rd_en, m_valid, m_data, m_last, buf_count)
//   slave  : FIFO/sink side (drives fifo_empty, fifo_rd_data, m_ready)
interface fifo_rd_stream_adapter_if
    import fifo_stream_pkg::*;
    #(parameter int DATA_WIDTH = 8);

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    occ_t                  buf_count;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, buf_count
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, buf_count
    );

endinterface

// File: rtl/fifo_rd_stream_adapter_rd_skid_buffer.sv
// rd_skid_buffer: 2-entry in-order buffer between the FIFO read data and the
// output stream. Head entry is always presented on o_data.
//   rd_clk, rd_reset_n : clock, async active-low reset
//   i_push, i_data     : write a word at the tail
//   i_pop              : drop the head word (caller guarantees o_occ != 0)
//   o_data, o_occ      : head word, registered occupancy 0..2
module rd_skid_buffer
    import fifo_stream_pkg::*;
    #(parameter int DATA_WIDTH = 8)
(
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output occ_t                  o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  r_head;
    occ_t                  r_occ;
    logic                  w_tail;

    // Push is never issued at occ=2, so occ[0] is enough to locate the tail.
    assign w_tail = r_head ^ r_occ[0];

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
            r_head <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (i_push) r_mem[w_tail] <= i_data;
            if (i_pop)  r_head <= ~r_head;
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + occ_t'(1);
                2'b01:   r_occ <= r_occ - occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_head];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns the async FIFO's registered read port
// (rd_en / 1-cycle-later rd_data) into a valid/ready stream at 1 word/cycle.
//   rd_clk, rd_reset_n : read-domain clock, async active-low reset
//   bus (master)       : fifo_empty/fifo_rd_en/fifo_rd_data,
//                        m_valid/m_ready/m_data/m_last, buf_count
// Optional feature macro FIFO_RD_STREAM_LAST_EN: m_last every PKT_LEN beats;
// without it m_last is constant 0.
module fifo_rd_stream_adapter
    import fifo_stream_pkg::*;
    #(
        parameter int DATA_WIDTH = 8,
        parameter int PKT_LEN    = 4
    )
(
    input  logic                     rd_clk,
    input  logic                     rd_reset_n,
    fifo_rd_stream_adapter_if.master bus
);

    if (PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_rd_stream_adapter: PKT_LEN must be >= 1");
    end

    logic                  r_inflight;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_rd_en;
    occ_t                  w_occ;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_valid = (w_occ != '0);
    assign w_pop   = w_valid && bus.m_ready;

    // Gated by reset so no read is requested while the adapter is held.
    assign w_rd_en = rd_reset_n && !bus.fifo_empty
                     && can_issue(w_occ, r_inflight, w_pop);

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) r_inflight <= 1'b0;
        else             r_inflight <= w_rd_en;
    end

    rd_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .i_push     (r_inflight),
        .i_data     (bus.fifo_rd_data),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_occ      (w_occ)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_head;
    assign bus.buf_count  = w_occ;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int BEAT_W = $clog2(PKT_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] r_beat;

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n)              r_beat <= '0;
        else if (w_pop) begin
            if (r_beat == LAST_BEAT)  r_beat <= '0;
            else                      r_beat <= r_beat + BEAT_W'(1);
        end
    end

    assign bus.m_last = w_valid && (r_beat == LAST_BEAT);
`else
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;
    import fifo_stream_pkg::*;

    localparam int DW = 8;

    logic rd_clk = 1'b0;
    logic rd_reset_n = 1'b0;
    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .PKT_LEN(4)) dut (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .bus        (bus)
    );

    // FIFO model: registered read data, holds stale data when not read.
    logic [DW-1:0] mem [128];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [DW-1:0] model_rd_data = '0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = model_rd_data;

    always @(posedge rd_clk) begin
        if (bus.fifo_rd_en) begin
            model_rd_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Monitor, sampled mid-cycle: transfers that the coming edge will take.
    logic [DW-1:0] rx_data [64];
    logic          rx_last [64];
    int            rx_n    = 0;
    int            rd_cnt  = 0;
    int            max_occ = 0;

    always @(negedge rd_clk) begin
        if (rd_reset_n) begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && bus.m_ready && rx_n < 64) begin
                rx_data[rx_n] = bus.m_data;
                rx_last[rx_n] = bus.m_last;
                rx_n++;
            end
            if (int'(bus.buf_count) > max_occ) max_occ = int'(bus.buf_count);
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic to_mid();
        @(negedge rd_clk);
    endtask

    task automatic to_drive();
        @(posedge rd_clk);
        #1;
    endtask

    int base;
    int rb;
    int budget;

    initial begin
        bus.m_ready = 1'b1;

        // Reset and idle
        #2;
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_data", 32'(bus.m_data), 0);
        chk("rst_count", 32'(bus.buf_count), 0);
        chk("rst_last", 32'(bus.m_last), 0);
        chk("rst_rden", 32'(bus.fifo_rd_en), 0);
        to_drive();
        to_drive();
        rd_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            to_mid();
            chk("idle_rden", 32'(bus.fifo_rd_en), 0);
            chk("idle_valid", 32'(bus.m_valid), 0);
            chk("idle_count", 32'(bus.buf_count), 0);
        end

        // Streaming 01..08, back-to-back
        to_drive();
        for (int i = 0; i < 8; i++) push(DW'(8'h01 + i));
        to_mid();
        chk("st_rden_t0", 32'(bus.fifo_rd_en), 1);
        chk("st_valid_t0", 32'(bus.m_valid), 0);
        to_mid();
        chk("st_valid_t1", 32'(bus.m_valid), 0);
        for (int i = 0; i < 8; i++) begin
            to_mid();
            chk("st_valid", 32'(bus.m_valid), 1);
            chk("st_data", 32'(bus.m_data), 32'(8'h01 + i));
            chk("st_last_off", 32'(bus.m_last), 0);
        end
        to_mid();
        chk("st_valid_end", 32'(bus.m_valid), 0);

        // Backpressure A0..A5
        to_drive();
        bus.m_ready = 1'b0;
        rb = rd_cnt;
        base = rx_n;
        for (int i = 0; i < 6; i++) push(DW'(8'hA0 + i));
        for (int i = 0; i < 6; i++) begin
            to_mid();
            if (i >= 2) begin
                chk("bp_valid", 32'(bus.m_valid), 1);
                chk("bp_data", 32'(bus.m_data), 32'h0A0);
            end
        end
        chk("bp_reads", 32'(rd_cnt - rb), 2);
        chk("bp_count", 32'(bus.buf_count), 2);
        to_drive();
        bus.m_ready = 1'b1;
        budget = 0;
        while (rx_n < base + 6 && budget < 40) begin
            to_drive();
            budget++;
        end
        chk("bp_rx_n", 32'(rx_n - base), 6);
        for (int i = 0; i < 6; i++) chk("bp_rx", 32'(rx_data[base + i]), 32'(8'hA0 + i));

        // Alternating ready, 16 words
        base = rx_n;
        for (int i = 0; i < 16; i++) push(DW'(8'h10 + i));
        budget = 0;
        while (rx_n < base + 16 && budget < 80) begin
            bus.m_ready = ~bus.m_ready;
            to_drive();
            budget++;
        end
        bus.m_ready = 1'b1;
        repeat (5) to_drive();
        chk("alt_rx_n", 32'(rx_n - base), 16);
        for (int i = 0; i < 16; i++) chk("alt_rx", 32'(rx_data[base + i]), 32'(8'h10 + i));
        chk("alt_max_occ", 32'(max_occ), 2);

        // Reset mid-stream
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
        repeat (4) to_mid();
        chk("mr_count_pre", 32'(bus.buf_count), 2);
        #2;
        rd_reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.m_valid), 0);
        chk("mr_count", 32'(bus.buf_count), 0);
        chk("mr_data", 32'(bus.m_data), 0);
        chk("mr_rden", 32'(bus.fifo_rd_en), 0);
        to_drive();
        to_drive();
        base = rx_n;
        rd_reset_n = 1'b1;
        bus.m_ready = 1'b1;
        to_mid();
        chk("mr_r0_valid", 32'(bus.m_valid), 0);
        chk("mr_r0_data", 32'(bus.m_data), 0);
        chk("mr_r0_rden", 32'(bus.fifo_rd_en), 1);
        to_mid();
        chk("mr_r1_valid", 32'(bus.m_valid), 0);
        chk("mr_r1_data", 32'(bus.m_data), 0);
        to_mid();
        chk("mr_r2_valid", 32'(bus.m_valid), 1);
        chk("mr_r2_data", 32'(bus.m_data), 32'h0C2);
        repeat (5) to_drive();
        chk("mr_rx_n", 32'(rx_n - base), 2);
        chk("mr_rx1", 32'(rx_data[base + 1]), 32'h0C3);

`ifdef FIFO_RD_STREAM_LAST_EN
        // Packet framing, PKT_LEN=4: clear beat counter first
        rd_reset_n = 1'b0;
        to_drive();
        rd_reset_n = 1'b1;
        base = rx_n;
        for (int i = 0; i < 12; i++) push(DW'(8'h30 + i));
        budget = 0;
        while (rx_n < base + 12 && budget < 40) begin
            to_drive();
            budget++;
        end
        chk("pk_rx_n", 32'(rx_n - base), 12);
        for (int i = 0; i < 12; i++)
            chk("pk_last", 32'(rx_last[base + i]), 32'((i % 4) == 3));

        // Stall on beat 4
        base = rx_n;
        for (int i = 0; i < 4; i++) push(DW'(8'h40 + i));
        budget = 0;
        while (rx_n < base + 3 && budget < 40) begin
            to_drive();
            budget++;
        end
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_mid();
            chk("pk_stall_last", 32'(bus.m_last), 1);
            chk("pk_stall_data", 32'(bus.m_data), 32'h043);
        end
        to_drive();
        bus.m_ready = 1'b1;
        repeat (3) to_drive();
        chk("pk2_rx_n", 32'(rx_n - base), 4);
        for (int i = 0; i < 4; i++)
            chk("pk2_last", 32'(rx_last[base + i]), 32'(i == 3));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
